// File: rtl/pll_reconfig_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pll_reconfig_ctrl_pkg
// Shared definitions for the PLL reconfiguration controller:
//   - controller FSM state enum
//   - PLL dynamic setting widths (divider selects 6 bits, phase/duty 4 bits)
//   - setting values applied on reset
//   - small constant helper for counter sizing
// -----------------------------------------------------------------------------
package pll_reconfig_ctrl_pkg;

  localparam int unsigned SEL_W = 6;
  localparam int unsigned DA_W  = 4;

  localparam logic [SEL_W-1:0] RST_IDSEL  = '0;
  localparam logic [SEL_W-1:0] RST_FBDSEL = '0;
  localparam logic [SEL_W-1:0] RST_ODSEL  = '0;
  localparam logic [DA_W-1:0]  RST_PSDA   = '0;
  localparam logic [DA_W-1:0]  RST_DUTYDA = 4'b1000;

  typedef enum logic [2:0] {
    RST_HOLD,
    WAIT_LOCK,
    STABLE,
    RUN,
    FAIL
  } pll_state_e;

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_reconfig_ctrl_sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchroniser bringing an asynchronous level into the i_clk domain.
// Ports:
//   i_clk  - destination clock
//   i_rst  - synchronous active-high reset (clears both stages)
//   i_d    - asynchronous input level
//   o_q    - synchronised output (two i_clk cycles of latency)
// -----------------------------------------------------------------------------
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_reconfig_ctrl.sv
// -----------------------------------------------------------------------------
// pll_reconfig_ctrl
// Sequences PLL reset, lock acquisition, lock qualification and dynamic
// reconfiguration. Retries lock a limited number of times before parking in
// FAIL; a new configuration request restarts the sequence from either RUN or
// FAIL.
// Parameters:
//   RST_CYCLES    - cycles pll_reset is held high per reset pulse
//   LOCK_TIMEOUT  - max cycles waiting for lock after reset release
//   STABLE_CYCLES - consecutive synchronised-lock cycles before clk_ok
//   MAX_RETRY     - timeouts tolerated before entering FAIL
// Ports:
//   clkin, reset                  - fabric clock, synchronous active-high reset
//   cfg_valid / cfg_ready         - configuration request handshake
//   cfg_idsel/fbdsel/odsel/psda/dutyda - requested settings
//   pll_lock                      - PLL LOCK (asynchronous)
//   pll_reset, pll_reset_p        - PLL RESET / RESET_P
//   pll_idsel/fbdsel/odsel/psda/dutyda - registered settings to the PLL
//   clk_ok                        - PLL clocks valid
//   busy, fail, retry_cnt         - status
//   lock_loss_cnt                 - saturating lock-loss count, only present
//                                   when PLL_LOCK_LOSS_CNT_EN is defined
// -----------------------------------------------------------------------------
module pll_reconfig_ctrl
  import pll_reconfig_ctrl_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 65535,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRY     = 3
) (
  input  logic             clkin,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [SEL_W-1:0] cfg_idsel,
  input  logic [SEL_W-1:0] cfg_fbdsel,
  input  logic [SEL_W-1:0] cfg_odsel,
  input  logic [DA_W-1:0]  cfg_psda,
  input  logic [DA_W-1:0]  cfg_dutyda,
  input  logic             pll_lock,
  output logic             pll_reset,
  output logic             pll_reset_p,
  output logic [SEL_W-1:0] pll_idsel,
  output logic [SEL_W-1:0] pll_fbdsel,
  output logic [SEL_W-1:0] pll_odsel,
  output logic [DA_W-1:0]  pll_psda,
  output logic [DA_W-1:0]  pll_dutyda,
  output logic             clk_ok,
`ifdef PLL_LOCK_LOSS_CNT_EN
  output logic [7:0]       lock_loss_cnt,
`endif
  output logic             busy,
  output logic             fail,
  output logic [1:0]       retry_cnt
);

  localparam int unsigned CNT_MAX = max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYCLES - 1);
  // retry_cnt is 2 bits wide, so larger limits collapse onto its maximum
  localparam logic [1:0] RETRY_LIMIT = (MAX_RETRY > 3) ? 2'd3 : 2'(MAX_RETRY);

  pll_state_e       r_state;
  pll_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [1:0]       r_retry;
  logic [1:0]       w_retry_nxt;
  logic [1:0]       w_retry_inc;
  logic             w_lock_s;
  logic             w_accept;

  logic [SEL_W-1:0] r_idsel;
  logic [SEL_W-1:0] r_fbdsel;
  logic [SEL_W-1:0] r_odsel;
  logic [DA_W-1:0]  r_psda;
  logic [DA_W-1:0]  r_dutyda;

`ifdef PLL_LOCK_LOSS_CNT_EN
  logic [7:0]       r_loss_cnt;
  logic             w_lock_loss;
`endif

  sync_2ff u_lock_sync (
    .i_clk (clkin),
    .i_rst (reset),
    .i_d   (pll_lock),
    .o_q   (w_lock_s)
  );

  assign w_cnt_inc   = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
  assign w_retry_inc = (r_retry == '1) ? r_retry : r_retry + 2'd1;

  // Status decode
  always_comb begin
    pll_reset = (r_state == RST_HOLD) || (r_state == FAIL);
    busy      = (r_state == RST_HOLD) || (r_state == WAIT_LOCK) || (r_state == STABLE);
    clk_ok    = (r_state == RUN);
    fail      = (r_state == FAIL);
    cfg_ready = (r_state == RUN) || (r_state == FAIL);
  end

  assign pll_reset_p = pll_reset;
  assign w_accept    = cfg_valid && cfg_ready;

  // Next-state / counter logic
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_retry_nxt = r_retry;
`ifdef PLL_LOCK_LOSS_CNT_EN
    w_lock_loss = 1'b0;
`endif
    unique case (r_state)
      RST_HOLD: begin
        if (r_cnt >= RST_LAST) begin
          w_state_nxt = WAIT_LOCK;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      WAIT_LOCK: begin
        if (w_lock_s) begin
          w_state_nxt = STABLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt >= TO_LAST) begin
          w_cnt_nxt = '0;
          if (r_retry >= RETRY_LIMIT) begin
            w_state_nxt = FAIL;
          end else begin
            w_state_nxt = RST_HOLD;
            w_retry_nxt = w_retry_inc;
          end
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      STABLE: begin
        if (!w_lock_s) begin
          w_state_nxt = WAIT_LOCK;
          w_cnt_nxt   = '0;
        end else if (r_cnt >= STB_LAST) begin
          w_state_nxt = RUN;
          w_cnt_nxt   = '0;
          w_retry_nxt = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      RUN: begin
        if (!w_lock_s) begin
          w_state_nxt = RST_HOLD;
          w_cnt_nxt   = '0;
`ifdef PLL_LOCK_LOSS_CNT_EN
          // a request arriving with the loss restarts anyway; not a loss event
          w_lock_loss = !w_accept;
`endif
        end
      end
      FAIL: begin
        w_state_nxt = FAIL;
      end
      default: begin
        w_state_nxt = RST_HOLD;
        w_cnt_nxt   = '0;
      end
    endcase
    // An accepted request overrides any lock-loss outcome in the same cycle
    if (w_accept) begin
      w_state_nxt = RST_HOLD;
      w_cnt_nxt   = '0;
      w_retry_nxt = '0;
    end
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      r_state <= RST_HOLD;
      r_cnt   <= '0;
      r_retry <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_retry <= w_retry_nxt;
    end
  end

  // Settings only move on acceptance, at the same edge pll_reset rises
  always_ff @(posedge clkin) begin
    if (reset) begin
      r_idsel  <= RST_IDSEL;
      r_fbdsel <= RST_FBDSEL;
      r_odsel  <= RST_ODSEL;
      r_psda   <= RST_PSDA;
      r_dutyda <= RST_DUTYDA;
    end else if (w_accept) begin
      r_idsel  <= cfg_idsel;
      r_fbdsel <= cfg_fbdsel;
      r_odsel  <= cfg_odsel;
      r_psda   <= cfg_psda;
      r_dutyda <= cfg_dutyda;
    end
  end

  assign pll_idsel  = r_idsel;
  assign pll_fbdsel = r_fbdsel;
  assign pll_odsel  = r_odsel;
  assign pll_psda   = r_psda;
  assign pll_dutyda = r_dutyda;
  assign retry_cnt  = r_retry;

`ifdef PLL_LOCK_LOSS_CNT_EN
  always_ff @(posedge clkin) begin
    if (reset) begin
      r_loss_cnt <= '0;
    end else if (w_lock_loss && (r_loss_cnt != '1)) begin
      r_loss_cnt <= r_loss_cnt + 8'd1;
    end
  end

  assign lock_loss_cnt = r_loss_cnt;
`endif

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pll_reconfig_ctrl
// Directed bench for pll_reconfig_ctrl with a phase-level reference model that
// is compared against all DUT outputs every cycle, plus hand-computed latency
// and value checks for each scenario. Define PLL_LOCK_LOSS_CNT_EN to also cover
// the lock-loss counter.
// -----------------------------------------------------------------------------
module tb_pll_reconfig_ctrl;

  localparam int unsigned RST_CYCLES    = 16;
  localparam int unsigned LOCK_TIMEOUT  = 40;
  localparam int unsigned STABLE_CYCLES = 1024;
  localparam int unsigned MAX_RETRY     = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [5:0] cfg_idsel = '0, cfg_fbdsel = '0, cfg_odsel = '0;
  logic [3:0] cfg_psda = '0, cfg_dutyda = 4'b1000;
  logic       pll_lock = 1'b0;
  logic       pll_reset, pll_reset_p, clk_ok, busy, fail;
  logic [5:0] pll_idsel, pll_fbdsel, pll_odsel;
  logic [3:0] pll_psda, pll_dutyda;
  logic [1:0] retry_cnt;
`ifdef PLL_LOCK_LOSS_CNT_EN
  logic [7:0] lock_loss_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pll_reconfig_ctrl #(
    .RST_CYCLES    (RST_CYCLES),
    .LOCK_TIMEOUT  (LOCK_TIMEOUT),
    .STABLE_CYCLES (STABLE_CYCLES),
    .MAX_RETRY     (MAX_RETRY)
  ) dut (
    .clkin         (clk),
    .reset         (reset),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_idsel     (cfg_idsel),
    .cfg_fbdsel    (cfg_fbdsel),
    .cfg_odsel     (cfg_odsel),
    .cfg_psda      (cfg_psda),
    .cfg_dutyda    (cfg_dutyda),
    .pll_lock      (pll_lock),
    .pll_reset     (pll_reset),
    .pll_reset_p   (pll_reset_p),
    .pll_idsel     (pll_idsel),
    .pll_fbdsel    (pll_fbdsel),
    .pll_odsel     (pll_odsel),
    .pll_psda      (pll_psda),
    .pll_dutyda    (pll_dutyda),
    .clk_ok        (clk_ok),
`ifdef PLL_LOCK_LOSS_CNT_EN
    .lock_loss_cnt (lock_loss_cnt),
`endif
    .busy          (busy),
    .fail          (fail),
    .retry_cnt     (retry_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic tick(input int k = 1);
    repeat (k) @(posedge clk);
    #2;
  endtask

  // ---------------- reference model ----------------
  // phase: 0 reset-hold, 1 waiting for lock, 2 qualifying lock, 3 running, 4 failed
  int         m_ph = 0;
  int         m_t = 0;
  int         m_retry = 0;
  int         m_loss = 0;
  logic       m_s1 = 1'b0, m_s2 = 1'b0, m_ls;
  bit         m_valid = 1'b0;
  logic [5:0] m_id, m_fb, m_od;
  logic [3:0] m_ps, m_du;

  always @(posedge clk) begin
    bit acc;
    m_ls = m_s2;
    m_s2 = m_s1;
    m_s1 = pll_lock;
    if (reset) begin
      m_ph = 0; m_t = 0; m_retry = 0; m_loss = 0;
      m_s1 = 1'b0; m_s2 = 1'b0;
      m_id = 6'd0; m_fb = 6'd0; m_od = 6'd0; m_ps = 4'd0; m_du = 4'd8;
      m_valid = 1'b1;
    end else begin
      acc = cfg_valid && (m_ph == 3 || m_ph == 4);
      case (m_ph)
        0: begin
          m_t++;
          if (m_t >= RST_CYCLES) begin m_ph = 1; m_t = 0; end
        end
        1: begin
          if (m_ls) begin
            m_ph = 2; m_t = 0;
          end else begin
            m_t++;
            if (m_t >= LOCK_TIMEOUT) begin
              m_t = 0;
              if (m_retry >= MAX_RETRY) m_ph = 4;
              else begin m_retry++; m_ph = 0; end
            end
          end
        end
        2: begin
          if (!m_ls) begin
            m_ph = 1; m_t = 0;
          end else begin
            m_t++;
            if (m_t >= STABLE_CYCLES) begin m_ph = 3; m_t = 0; m_retry = 0; end
          end
        end
        3: if (!acc && !m_ls) begin m_ph = 0; m_t = 0; m_loss++; end
        default: ;
      endcase
      if (acc) begin
        m_ph = 0; m_t = 0; m_retry = 0;
        m_id = cfg_idsel; m_fb = cfg_fbdsel; m_od = cfg_odsel;
        m_ps = cfg_psda; m_du = cfg_dutyda;
      end
    end
  end

  always @(negedge clk) begin
    logic [33:0] a, e;
    if (m_valid) begin
      a = {pll_reset, pll_reset_p, clk_ok, busy, fail, cfg_ready, retry_cnt,
           pll_idsel, pll_fbdsel, pll_odsel, pll_psda, pll_dutyda};
      e = {(m_ph == 0 || m_ph == 4), (m_ph == 0 || m_ph == 4), (m_ph == 3),
           (m_ph <= 2), (m_ph == 4), (m_ph >= 3), 2'(m_retry),
           m_id, m_fb, m_od, m_ps, m_du};
      chk("model_outputs", a, e);
`ifdef PLL_LOCK_LOSS_CNT_EN
      chk("model_lock_loss_cnt", lock_loss_cnt, m_loss);
`endif
    end
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int n, hi, early;
    logic prev;
    logic [1:0] seen[$];

    // reset values
    reset = 1'b1;
    tick(2);
    chk("rst_pll_reset", pll_reset, 1);
    chk("rst_pll_reset_p", pll_reset_p, 1);
    chk("rst_dutyda", pll_dutyda, 4'b1000);
    chk("rst_idsel", pll_idsel, 0);
    chk("rst_clk_ok", clk_ok, 0);
    chk("rst_busy", busy, 1);
    chk("rst_cfg_ready", cfg_ready, 0);
    chk("rst_fail", fail, 0);
    chk("rst_retry", retry_cnt, 0);
    reset = 1'b0;

    // first lock: reset width, then lock 5 cycles after release
    n = 0;
    do begin tick(); n++; end while (pll_reset && n < 200);
    chk("s1_reset_width", n, 16);
    tick(5);
    pll_lock = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!clk_ok && n < 3000);
    chk("s1_clk_ok_latency", n, 1027);
    chk("s1_retry", retry_cnt, 0);
    chk("s1_cfg_ready", cfg_ready, 1);

    // request in RUN
    cfg_idsel = 6'd3; cfg_fbdsel = 6'd9; cfg_odsel = 6'd8; cfg_psda = 4'd2; cfg_dutyda = 4'd6;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    chk("s3_idsel", pll_idsel, 3);
    chk("s3_fbdsel", pll_fbdsel, 9);
    chk("s3_odsel", pll_odsel, 8);
    chk("s3_psda_dutyda", {pll_psda, pll_dutyda}, 8'h26);
    chk("s3_pll_reset", pll_reset, 1);
    chk("s3_clk_ok", clk_ok, 0);
    chk("s3_cfg_ready", cfg_ready, 0);
    n = 0;
    do begin tick(); n++; end while (!clk_ok && n < 3000);
    chk("s3_relock_latency", n, 1041);

    // one-cycle lock drop in RUN
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    n = 1;
    while (clk_ok && n < 20) begin tick(); n++; end
    chk("s4_loss_detect", n, 3);
    n = 0;
    do begin tick(); n++; end while (!clk_ok && n < 3000);
    chk("s4_relock_latency", n, 1041);
`ifdef PLL_LOCK_LOSS_CNT_EN
    chk("s4_lock_loss_cnt", lock_loss_cnt, 1);
`endif

    // reset in RUN, then lock glitch at stable count 500
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("s5_reset_clk_ok", clk_ok, 0);
    chk("s5_reset_pll_reset", pll_reset, 1);
    chk("s5_reset_idsel", pll_idsel, 0);
    n = 0;
    do begin tick(); n++; end while (pll_reset && n < 200);
    chk("s5_reset_width", n, 16);
    tick(499);
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    n = 0; hi = 0;
    do begin tick(); n++; if (pll_reset) hi++; end while (!clk_ok && n < 3000);
    chk("s5_glitch_relock", n, 1027);
    chk("s5_no_reset_pulse", hi, 0);
    chk("s5_retry", retry_cnt, 0);

    // lock lost for good: three retries, then FAIL; request held off meanwhile
    pll_lock = 1'b0;
    n = 0;
    do begin tick(); n++; end while (clk_ok && n < 20);
    chk("s2_loss_detect", n, 3);
    cfg_idsel = 6'd5; cfg_fbdsel = 6'd11; cfg_odsel = 6'd2; cfg_psda = 4'd3; cfg_dutyda = 4'd9;
    cfg_valid = 1'b1;
    prev = pll_reset;
    early = 0;
    n = 0;
    do begin
      tick(); n++;
      if (pll_reset && !prev && !fail) seen.push_back(retry_cnt);
      if (!fail && pll_idsel != 6'd0) early++;
      prev = pll_reset;
    end while (!fail && n < 1000);
    chk("s2_time_to_fail", n, 224);
    chk("s2_retry_rises", seen.size(), 3);
    while (seen.size() < 3) seen.push_back(2'b00);
    chk("s2_retry_sequence", {seen[0], seen[1], seen[2]}, 6'b01_10_11);
    chk("s2_held_off", early, 0);
    chk("s2_fail", fail, 1);
    chk("s2_cfg_ready", cfg_ready, 1);
    chk("s2_pll_reset", pll_reset, 1);
    chk("s2_clk_ok", clk_ok, 0);
    chk("s2_retry", retry_cnt, 3);
    tick();
    cfg_valid = 1'b0;
    chk("s2_accept_settings", {pll_idsel, pll_fbdsel, pll_odsel, pll_psda, pll_dutyda},
        {6'd5, 6'd11, 6'd2, 4'd3, 4'd9});
    chk("s2_accept_fail", fail, 0);
    chk("s2_accept_retry", retry_cnt, 0);
    chk("s2_accept_busy", busy, 1);

    // reset during WAIT_LOCK after one timeout
    n = 0;
    do begin tick(); n++; end while (pll_reset && n < 200);
    chk("s6_reset_width", n, 16);
    n = 0;
    do begin tick(); n++; end while (!pll_reset && n < 200);
    chk("s6_timeout", n, 40);
    chk("s6_retry1", retry_cnt, 1);
    n = 0;
    do begin tick(); n++; end while (pll_reset && n < 200);
    tick(10);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("s6_pll_reset", pll_reset, 1);
    chk("s6_dutyda", pll_dutyda, 4'b1000);
    chk("s6_idsel", pll_idsel, 0);
    chk("s6_retry", retry_cnt, 0);
    chk("s6_busy", busy, 1);
    n = 0;
    do begin tick(); n++; end while (pll_reset && n < 200);
    chk("s6_reset_width_after", n, 16);
    pll_lock = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!clk_ok && n < 3000);
    chk("s6_clk_ok_latency", n, 1027);

    // lock loss coinciding with a request: new settings win
    pll_lock = 1'b0;
    tick(2);
    cfg_idsel = 6'd12; cfg_fbdsel = 6'd20; cfg_odsel = 6'd1; cfg_psda = 4'd7; cfg_dutyda = 4'd3;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    pll_lock = 1'b1;
    chk("s7_idsel", pll_idsel, 12);
    chk("s7_pll_reset", pll_reset, 1);
    chk("s7_clk_ok", clk_ok, 0);
`ifdef PLL_LOCK_LOSS_CNT_EN
    chk("s7_lock_loss_cnt", lock_loss_cnt, 0);
`endif
    n = 0;
    do begin tick(); n++; end while (!clk_ok && n < 3000);
    chk("s7_relock_latency", n, 1041);
    chk("s7_settings_kept", {pll_idsel, pll_fbdsel, pll_odsel}, {6'd12, 6'd20, 6'd1});

    tick(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    n_bad++;
    $display("FAIL watchdog @%0t: got timeout expected completion", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pll_reconfig_ctrl.md
PLL_RECONFIG_CTRL -- requirements
Module: pll_reconfig_ctrl

Interface
REQ-001 The block SHALL have parameter RST_CYCLES, default 16: number of cycles pll_reset is held high.
REQ-002 The block SHALL have parameter LOCK_TIMEOUT, default 65535: maximum number of cycles to wait for lock after reset release.
REQ-003 The block SHALL have parameter STABLE_CYCLES, default 1024: number of consecutive synchronised-lock cycles required before clk_ok is asserted.
REQ-004 The block SHALL have parameter MAX_RETRY, default 3: number of lock retries allowed before entering FAIL.
REQ-005 The block SHALL have port clkin, input, 1 bit: fabric clock; all logic is on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have ports cfg_valid, input, 1 bit, and cfg_ready, output, 1 bit: configuration request handshake.
REQ-008 The block SHALL have ports cfg_idsel, cfg_fbdsel and cfg_odsel, input, 6 bits each, and cfg_psda and cfg_dutyda, input, 4 bits each: requested PLL dynamic settings.
REQ-009 The block SHALL have port pll_lock, input, 1 bit: PLL LOCK, asynchronous to clkin.
REQ-010 The block SHALL have ports pll_reset and pll_reset_p, output, 1 bit each: PLL RESET and RESET_P.
REQ-011 The block SHALL have ports pll_idsel, pll_fbdsel and pll_odsel, output, 6 bits each, and pll_psda and pll_dutyda, output, 4 bits each: registered settings driven to the PLL.
REQ-012 The block SHALL have port clk_ok, output, 1 bit: PLL output clocks are valid, used as downstream reset release.
REQ-013 The block SHALL have ports busy and fail, output, 1 bit each, and retry_cnt, output, 2 bits: status.

Function
REQ-014 pll_lock SHALL pass through a 2-flop synchroniser; lock_s denotes the synchroniser output, and all lock decisions SHALL use lock_s only.
REQ-015 The FSM SHALL have exactly the states RST_HOLD, WAIT_LOCK, STABLE, RUN and FAIL.
REQ-016 RST_HOLD: pll_reset and pll_reset_p SHALL be 1 for exactly RST_CYCLES cycles, then the FSM SHALL move to WAIT_LOCK with the cycle counter cleared.
REQ-017 WAIT_LOCK: when lock_s=1 the FSM SHALL move to STABLE; if the counter reaches LOCK_TIMEOUT first, it SHALL move to RST_HOLD and increment retry_cnt.
REQ-018 Retry exhaustion: if retry_cnt equals MAX_RETRY when a timeout occurs, the FSM SHALL move to FAIL instead of RST_HOLD.
REQ-019 STABLE: the FSM SHALL count consecutive lock_s=1 cycles; lock_s=0 SHALL return it to WAIT_LOCK with the counter cleared and retry_cnt unchanged; on reaching STABLE_CYCLES it SHALL move to RUN and clear retry_cnt.
REQ-020 RUN: clk_ok SHALL be 1; lock_s=0 for one or more cycles SHALL deassert clk_ok on the next cycle and move the FSM to RST_HOLD (lock loss).
REQ-021 FAIL: fail SHALL be 1, pll_reset SHALL be 1 and clk_ok SHALL be 0; the FSM SHALL leave FAIL only on reset or an accepted request.
REQ-022 cfg_ready SHALL be 1 only in RUN and FAIL.
REQ-023 A request SHALL be accepted on the cycle cfg_valid and cfg_ready are both 1: all cfg_* SHALL be latched into pll_*, retry_cnt cleared, and the FSM moved to RST_HOLD on the next cycle.
REQ-024 cfg_valid while cfg_ready=0 SHALL be held off and not dropped; the requester holds the values stable until accepted.
REQ-025 When lock loss and a request coincide in RUN, the request SHALL be accepted and the relock SHALL use the new settings.
REQ-026 busy SHALL equal 1 in RST_HOLD, WAIT_LOCK and STABLE.
REQ-027 pll_* settings SHALL change only on acceptance or reset, and SHALL never change while pll_reset=0.
REQ-028 Counters SHALL be wide enough for the largest parameter and SHALL saturate, never wrap.

Reset
REQ-029 On reset the FSM SHALL enter RST_HOLD with all counters 0, and clk_ok, fail and cfg_ready SHALL be 0.
REQ-030 On reset pll_reset and pll_reset_p SHALL be 1, and busy SHALL be 1.
REQ-031 On reset the settings SHALL be pll_idsel=0, pll_fbdsel=0, pll_odsel=0, pll_psda=0 and pll_dutyda=4'b1000.
REQ-032 Reset asserted mid-operation SHALL abort any sequence within one cycle and restart from RST_HOLD.

Configuration
REQ-033 With macro PLL_LOCK_LOSS_CNT_EN defined, the block SHALL add output lock_loss_cnt (8 bits, saturating, reset 0), incremented on each RUN-to-RST_HOLD lock-loss transition and not on accepted requests.
REQ-034 Without PLL_LOCK_LOSS_CNT_EN, neither the lock_loss_cnt port nor its logic SHALL exist.

Structure
REQ-035 A shared package SHALL hold the FSM state enum, the setting widths (6 and 4 bits) and the reset setting constants.
REQ-036 The synchroniser SHALL be a sub-module named sync_2ff; all other logic SHALL reside in one module.

Verification
REQ-037 Scenario: reset, then lock rising 5 cycles after pll_reset falls -> pll_reset high for 16 cycles, clk_ok=1 after 1024 stable cycles, and retry_cnt=0.
REQ-038 Scenario: lock never asserts -> 3 timeouts with retry_cnt 1, 2, 3, then fail=1, cfg_ready=1 and pll_reset=1.
REQ-039 Scenario: request in RUN with idsel=3, fbdsel=9 and odsel=8 -> one-cycle handshake, pll_* updated while pll_reset=1, clk_ok=0 until relock.
REQ-040 Scenario: lock drops for 1 cycle in RUN -> clk_ok=0 next cycle and a full relock sequence; with PLL_LOCK_LOSS_CNT_EN, lock_loss_cnt=1.
REQ-041 Scenario: lock glitch low during STABLE at count 500 -> FSM returns to WAIT_LOCK, stable count restarts, retry_cnt unchanged.
REQ-042 Scenario: reset pulse during WAIT_LOCK -> RST_HOLD next cycle, pll_dutyda=4'b1000, and all counters 0.
